// File: rtl/ravenoc_axi_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// ravenoc_axi_wr_arbiter_if
// One AXI write channel bundle (AW/W/B). It is parameterised by N so that the
// same bundle can carry N requesters packed side by side (slice i of every
// vector belongs to requester i), or a single port when N=1.
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where VALID and READY are both 1. VALID must not wait for READY.
//
// Modports:
//   master - drives AW/W payload and valids plus BREADY
//   slave  - drives AWREADY, WREADY, BVALID and BRESP
// BRESP is 2 bits regardless of N: it is broadcast to all slices.
// ---------------------------------------------------------------------------
interface ravenoc_axi_wr_arbiter_if #(
  parameter int N          = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ALEN_WIDTH = 8
);
  logic [N-1:0]            awvalid;
  logic [N*ADDR_WIDTH-1:0] awaddr;
  logic [N*ALEN_WIDTH-1:0] awlen;
  logic [N-1:0]            awready;
  logic [N-1:0]            wvalid;
  logic [N*DATA_WIDTH-1:0] wdata;
  logic [N-1:0]            wlast;
  logic [N-1:0]            wready;
  logic [N-1:0]            bvalid;
  logic [1:0]              bresp;
  logic [N-1:0]            bready;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ravenoc_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// ravenoc_axi_wr_arbiter
// Round-robin arbiter that lets N_REQ AXI write requesters share a single AXI
// write port into a RaveNoC network interface. One requester owns the port
// for a whole transaction (AW handshake, every W beat, the B handshake); then
// priority rotates to the requester after the owner.
//
// Ports:
//   clk_axi   - AXI clock, the only clock
//   arst_axi  - asynchronous active-low reset
//   s         - requester side, N_REQ packed channels (slave modport)
//   m         - network-interface side, single channel (master modport)
//   grant     - one-hot owner of the port, 0 when idle
//   len_err   - one-cycle pulse on a W handshake whose WLAST disagrees with
//               the beat count implied by AWLEN
//   dbg_state - current FSM state (0 IDLE, 1 ARB, 2 ADDR, 3 DATA, 4 RESP)
//
// Handshakes follow strict AXI valid/ready: a transfer occurs on the clock
// edge where VALID and READY are both high; the arbiter forwards valid and
// ready combinationally between the owner's slice and the NI port, so it
// neither adds latency per beat nor creates a transfer on its own.
// ---------------------------------------------------------------------------
module ravenoc_axi_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ALEN_WIDTH = 8
) (
  input  logic                          clk_axi,
  input  logic                          arst_axi,
  ravenoc_axi_wr_arbiter_if.slave       s,
  ravenoc_axi_wr_arbiter_if.master      m,
  output logic [N_REQ-1:0]              grant,
  output logic                          len_err,
  output logic [2:0]                    dbg_state
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [IDXW-1:0]       rr_ptr;
  logic [IDXW-1:0]       gidx;       // binary index of the current owner
  logic [ALEN_WIDTH-1:0] len_q;
  // One extra bit so that AWLEN all-ones (max burst) never wraps the count.
  logic [ALEN_WIDTH:0]   beat_cnt;
  logic                  beat_last;

  logic                  sel_found;
  logic [IDXW-1:0]       sel_idx;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

  assign dbg_state = state;
  assign beat_last = (beat_cnt == {1'b0, len_q});

  // -------------------------------------------------------------------------
  // Round-robin pick: first requester with AWVALID, scanning upward from
  // rr_ptr modulo N_REQ. Iterating from the far end lets the nearest
  // candidate overwrite the others, so no priority encoder chain is needed.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int cand;
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (s.awvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(cand);
      end
    end
  end

  // Handshakes on the shared port; the owner's slice mirrors them exactly.
  assign aw_hs = m.awvalid & m.awready;
  assign w_hs  = m.wvalid & m.wready;
  assign b_hs  = m.bvalid & m.bready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (|s.awvalid) state_next = ARB;
      // A request that vanished before arbitration is an AXI violation;
      // fall back to IDLE rather than granting nobody.
      ARB:  state_next = sel_found ? ADDR : IDLE;
      ADDR: if (aw_hs) state_next = DATA;
      DATA: if (w_hs && beat_last) state_next = RESP;
      RESP: if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Everything is steered by the registered owner index, so a
  // new request can never disturb a transaction in flight.
  // -------------------------------------------------------------------------
  always_comb begin
    m.awvalid = 1'b0;
    m.awaddr  = '0;
    m.awlen   = '0;
    m.wvalid  = 1'b0;
    m.wdata   = '0;
    m.wlast   = 1'b0;
    m.bready  = 1'b0;
    s.awready = '0;
    s.wready  = '0;
    s.bvalid  = '0;
    s.bresp   = m.bresp;
    len_err   = 1'b0;
    unique case (state)
      ADDR: begin
        m.awvalid       = s.awvalid[gidx];
        m.awaddr        = s.awaddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
        m.awlen         = s.awlen[gidx*ALEN_WIDTH +: ALEN_WIDTH];
        s.awready[gidx] = m.awready;
      end
      DATA: begin
        m.wvalid       = s.wvalid[gidx];
        m.wdata        = s.wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
        // WLAST comes from our own beat count; the requester's WLAST is
        // only compared against it to flag a malformed burst.
        m.wlast        = beat_last;
        s.wready[gidx] = m.wready;
        len_err        = s.wvalid[gidx] & m.wready &
                         (s.wlast[gidx] != beat_last);
      end
      RESP: begin
        s.bvalid[gidx] = m.bvalid;
        m.bready       = s.bready[gidx];
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant, rotation pointer and burst bookkeeping.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      rr_ptr   <= '0;
      gidx     <= '0;
      grant    <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        ARB: begin
          gidx  <= sel_idx;
          grant <= '0;
          if (sel_found) grant[sel_idx] <= 1'b1;
        end
        ADDR: begin
          if (aw_hs) begin
            len_q    <= s.awlen[gidx*ALEN_WIDTH +: ALEN_WIDTH];
            beat_cnt <= '0;
          end
        end
        DATA: begin
          if (w_hs) beat_cnt <= beat_cnt + 1'b1;
        end
        RESP: begin
          if (b_hs) begin
            rr_ptr <= (gidx == IDXW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            grant  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ravenoc_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ravenoc_axi_wr_arbiter
// Bench for the round-robin AXI write arbiter. Requester drivers push the
// expected AW and W traffic into queues; a negedge monitor on the NI side
// pops and compares. A small NI model answers with B after the last beat.
// ---------------------------------------------------------------------------
module tb_ravenoc_axi_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic clk_axi = 1'b0;
  logic arst_axi;
  always #5 clk_axi = ~clk_axi;

  logic [N-1:0] grant;
  logic         len_err;
  logic [2:0]   dbg_state;

  ravenoc_axi_wr_arbiter_if #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALEN_WIDTH(LW)) s_if ();
  ravenoc_axi_wr_arbiter_if #(.N(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALEN_WIDTH(LW)) m_if ();

  ravenoc_axi_wr_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALEN_WIDTH(LW)
  ) dut (
    .clk_axi   (clk_axi),
    .arst_axi  (arst_axi),
    .s         (s_if),
    .m         (m_if),
    .grant     (grant),
    .len_err   (len_err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [DW+1:0]      exp_q[$];      // {len_err, wlast, wdata} per beat
  logic [N+LW+AW-1:0] exp_aw_q[$];   // {grant, awlen, awaddr} per transaction
  int                 aw_cyc_q[$];
  logic [DW+1:0]      w_exp;
  logic [N+LW+AW-1:0] aw_exp;

  // NI model controls
  logic       b_pend    = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  logic       aw_rdy    = 1'b1;
  logic [7:0] wr_pat    = 8'h01;
  int         pat_len   = 1;
  int         pat_i     = 0;
  int         w_hs_cnt  = 0;
  int         last_aw_lat = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_axi) cyc++;

  // ---------------- NI model (drives right after the edge) ----------------
  initial begin
    m_if.awready = '0;
    m_if.wready  = '0;
    m_if.bvalid  = '0;
    m_if.bresp   = 2'b00;
    forever begin
      @(posedge clk_axi);
      #1;
      m_if.awready[0] = aw_rdy;
      m_if.wready[0]  = wr_pat[pat_i];
      pat_i           = (pat_i + 1) % pat_len;
      m_if.bvalid[0]  = b_pend;
      m_if.bresp      = b_pend ? bresp_cfg : 2'b00;
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk_axi) begin
    if (arst_axi) begin
      check("leak", 64'((s_if.awready | s_if.wready | s_if.bvalid) & ~grant), 64'd0);
      if (m_if.awvalid[0] && m_if.awready[0]) begin
        aw_cyc_q.push_back(cyc);
        if (exp_aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin
          aw_exp = exp_aw_q.pop_front();
          check("aw_grant_len_addr", 64'({grant, m_if.awlen, m_if.awaddr}), 64'(aw_exp));
        end
      end
      if (m_if.wvalid[0] && m_if.wready[0]) begin
        w_hs_cnt++;
        if (m_if.wlast[0]) b_pend = 1'b1;
        if (exp_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin
          w_exp = exp_q.pop_front();
          check("w_err_last_data", 64'({len_err, m_if.wlast[0], m_if.wdata}), 64'(w_exp));
        end
      end else if (len_err) begin
        check("len_err_no_hs", 64'd1, 64'd0);
      end
      if ((s_if.bvalid & s_if.bready) != '0)
        check("b_owner_resp", 64'({s_if.bvalid, s_if.bresp}), 64'({grant, bresp_cfg}));
      if (m_if.bvalid[0] && m_if.bready[0]) b_pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    s_if.awvalid = '0;
    s_if.awaddr  = '0;
    s_if.awlen   = '0;
    s_if.wvalid  = '0;
    s_if.wdata   = '0;
    s_if.wlast   = '0;
    s_if.bready  = '0;
  endtask

  task automatic do_reset();
    arst_axi = 1'b0;
    clear_inputs();
    b_pend = 1'b0;
    m_if.bvalid = '0;
    repeat (2) @(posedge clk_axi);
    #1 arst_axi = 1'b1;
    @(posedge clk_axi);
    #1;
  endtask

  // mode 0: correct WLAST; 1: WLAST high from beat 0 on; 2: WLAST never set
  task automatic write_txn(input int r, input logic [AW-1:0] addr, input int len,
                           input logic [DW-1:0] dbase, input int mode);
    logic [N-1:0] oh;
    logic req_last, int_last;
    int t;
    bit done;
    oh = '0;
    oh[r] = 1'b1;
    exp_aw_q.push_back({oh, LW'(len), addr});
    for (int b = 0; b <= len; b++) begin
      int_last = (b == len);
      req_last = (mode == 0) ? int_last : (mode == 1);
      exp_q.push_back({req_last != int_last, int_last, dbase + DW'(b)});
    end
    s_if.awvalid[r]           = 1'b1;
    s_if.awaddr[r*AW +: AW]   = addr;
    s_if.awlen[r*LW +: LW]    = LW'(len);
    done = 0;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk_axi);
      if (s_if.awready[r]) begin last_aw_lat = t; done = 1; end
      t++;
    end
    @(posedge clk_axi);
    #1 s_if.awvalid[r] = 1'b0;
    if (!done) begin check("aw_timeout", 64'd0, 64'd1); return; end
    for (int b = 0; b <= len; b++) begin
      s_if.wvalid[r]          = 1'b1;
      s_if.wdata[r*DW +: DW]  = dbase + DW'(b);
      s_if.wlast[r]           = (mode == 0) ? (b == len) : (mode == 1);
      done = 0;
      t = 0;
      while (!done && t < 50) begin
        @(negedge clk_axi);
        if (s_if.wready[r]) done = 1;
        t++;
      end
      @(posedge clk_axi);
      #1;
      if (!done) begin check("w_timeout", 64'd0, 64'd1); s_if.wvalid[r] = 1'b0; return; end
    end
    s_if.wvalid[r] = 1'b0;
    s_if.wlast[r]  = 1'b0;
    s_if.bready[r] = 1'b1;
    done = 0;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk_axi);
      if (s_if.bvalid[r]) done = 1;
      t++;
    end
    @(posedge clk_axi);
    #1 s_if.bready[r] = 1'b0;
    if (!done) check("b_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, nb, t;
    arst_axi = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_axi);
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_outs", 64'({m_if.awvalid, m_if.wvalid, m_if.bready, s_if.awready,
                           s_if.wready, s_if.bvalid, len_err}), 64'd0);
    arst_axi = 1'b1;
    @(posedge clk_axi);
    #1;

    // single requester, 4-beat burst
    write_txn(2, 32'h0000_2000, 3, 32'hA0, 0);
    check("aw_latency", 64'(last_aw_lat), 64'd2);
    check("grant_after_b", 64'(grant), 64'd0);

    // error response is passed through to the owner
    bresp_cfg = 2'b10;
    write_txn(0, 32'h0000_0040, 0, 32'h55, 0);
    bresp_cfg = 2'b00;

    // W backpressure 1,0,0,1
    base = w_hs_cnt;
    wr_pat = 8'b0000_1001;
    pat_len = 4;
    write_txn(3, 32'h0000_3000, 3, 32'hC0, 0);
    check("bp_beats", 64'(w_hs_cnt - base), 64'd4);
    wr_pat = 8'h01;
    pat_len = 1;
    pat_i = 0;

    // WLAST/AWLEN mismatches
    write_txn(1, 32'h0000_1100, 1, 32'hD0, 1);
    write_txn(1, 32'h0000_1200, 1, 32'hE0, 2);

    // round-robin with all four requesting continuously
    do_reset();
    aw_cyc_q.delete();
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[i % N] = 1'b1;
      exp_aw_q.push_back({oh, LW'(0), AW'(32'h100 * ((i % N) + 1))});
      exp_q.push_back({1'b0, 1'b1, DW'(32'hB0 + (i % N))});
    end
    for (int r = 0; r < N; r++) begin
      s_if.awvalid[r]         = 1'b1;
      s_if.awaddr[r*AW +: AW] = AW'(32'h100 * (r + 1));
      s_if.awlen[r*LW +: LW]  = '0;
      s_if.wvalid[r]          = 1'b1;
      s_if.wdata[r*DW +: DW]  = DW'(32'hB0 + r);
      s_if.wlast[r]           = 1'b1;
      s_if.bready[r]          = 1'b1;
    end
    nb = 0;
    t = 0;
    while (nb < 5 && t < 100) begin
      @(negedge clk_axi);
      if ((s_if.bvalid & s_if.bready) != '0) nb++;
      t++;
    end
    @(posedge clk_axi);
    #1 clear_inputs();
    check("rr_b_count", 64'(nb), 64'd5);
    check("rr_aw_count", 64'(aw_cyc_q.size()), 64'd5);
    for (int i = 1; i < aw_cyc_q.size(); i++)
      check("rr_period", 64'(aw_cyc_q[i] - aw_cyc_q[i-1]), 64'd5);
    repeat (2) @(posedge clk_axi);
    #1;

    // maximum burst length
    base = w_hs_cnt;
    write_txn(0, 32'h0000_4000, 255, 32'h1000, 0);
    check("max_beats", 64'(w_hs_cnt - base), 64'd256);

    // reset in the middle of DATA, with rr_ptr left at 2
    do_reset();
    write_txn(1, 32'h0000_5000, 0, 32'h77, 0);
    wr_pat = 8'h00;
    exp_aw_q.push_back({4'b0010, LW'(3), 32'h0000_6000});
    s_if.awvalid[1]         = 1'b1;
    s_if.awaddr[1*AW +: AW] = 32'h0000_6000;
    s_if.awlen[1*LW +: LW]  = 8'd3;
    t = 0;
    while (t < 50) begin
      @(negedge clk_axi);
      t++;
      if (s_if.awready[1]) break;
    end
    @(posedge clk_axi);
    #1;
    s_if.awvalid[1]         = 1'b0;
    s_if.wvalid[1]          = 1'b1;
    s_if.wdata[1*DW +: DW]  = 32'hF0;
    @(negedge clk_axi);
    check("mid_grant", 64'(grant), 64'b0010);
    check("mid_wvalid", 64'(m_if.wvalid), 64'd1);
    arst_axi = 1'b0;
    #1;
    check("abort_grant", 64'(grant), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    check("abort_outs", 64'({m_if.awvalid, m_if.wvalid, m_if.bready, s_if.awready,
                             s_if.wready, s_if.bvalid, len_err}), 64'd0);
    clear_inputs();
    b_pend = 1'b0;
    wr_pat = 8'h01;
    aw_rdy = 1'b0;
    @(posedge clk_axi);
    #1 arst_axi = 1'b1;
    @(posedge clk_axi);
    #1;
    s_if.awvalid[0] = 1'b1;
    s_if.awvalid[3] = 1'b1;
    repeat (3) @(negedge clk_axi);
    check("post_abort_grant", 64'(grant), 64'b0001);
    do_reset();
    aw_rdy = 1'b1;

    check("aw_q_empty", 64'(exp_aw_q.size()), 64'd0);
    check("w_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ravenoc_axi_wr_arbiter.md
# ravenoc_axi_wr_arbiter

Round-robin write-channel arbiter that lets NOC_SIZE-style AXI write requesters share one AXI write port (AW/W/B) into a RaveNoC network interface. It grants one requester at a time and holds the grant for the whole transaction: address handshake, every data beat through WLAST, then the write response. It then rotates priority. It sits on the AXI clock domain, in front of a single NI slave port, and replaces static select-based muxing when several masters drive one router.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- ADDR_WIDTH, 32, AWADDR width
- DATA_WIDTH, 32, WDATA width
- ALEN_WIDTH, 8, AWLEN width

Ports:
- clk_axi  in  1  AXI clock; the only clock
- arst_axi  in  1  asynchronous, active-low reset
- s_awvalid  in  N_REQ  per-requester AWVALID
- s_awaddr  in  N_REQ*ADDR_WIDTH  packed AWADDR; requester i is at slice i
- s_awlen  in  N_REQ*ALEN_WIDTH  packed AWLEN
- s_awready  out  N_REQ  per-requester AWREADY
- s_wvalid  in  N_REQ  per-requester WVALID
- s_wdata  in  N_REQ*DATA_WIDTH  packed WDATA
- s_wlast  in  N_REQ  per-requester WLAST
- s_wready  out  N_REQ  per-requester WREADY
- s_bvalid  out  N_REQ  per-requester BVALID
- s_bresp  out  2  BRESP, broadcast; meaningful only with s_bvalid
- s_bready  in  N_REQ  per-requester BREADY
- m_awvalid/m_awaddr/m_awlen  out  1/ADDR_WIDTH/ALEN_WIDTH  to NI
- m_awready  in  1
- m_wvalid/m_wdata/m_wlast  out  1/DATA_WIDTH/1  to NI
- m_wready  in  1
- m_bvalid/m_bresp  in  1/2  from NI
- m_bready  out  1
- grant  out  N_REQ  one-hot grant of the current owner; 0 when idle
- len_err  out  1  one-cycle pulse on a WLAST/AWLEN mismatch

## Operation
- FSM states are IDLE, ARB, ADDR, DATA and RESP.
- **IDLE:**
  - If any s_awvalid is set, go to ARB.
  - All ready/valid outputs are 0.
- **ARB (1 cycle):**
  - Pick the first requester with s_awvalid=1, scanning from rr_ptr upward modulo N_REQ.
  - Register the one-hot grant, then go to ADDR.
  - If the request dropped (illegal under AXI), return to IDLE with grant cleared.
- **ADDR:**
  - m_awvalid/m_awaddr/m_awlen are driven from the granted slice; s_awready[g]=m_awready.
  - On the handshake: capture awlen into len_q, clear beat_cnt, go to DATA.
- **DATA:**
  - m_wvalid=s_wvalid[g], m_wdata from slice g, s_wready[g]=m_wready.
  - m_wlast=(beat_cnt==len_q), generated internally and never taken from the requester.
  - Each W handshake increments beat_cnt.
  - Leave DATA on the handshake where beat_cnt==len_q, then go to RESP.
  - len_err pulses in the cycle of a handshake where s_wlast[g] != (beat_cnt==len_q). The transfer still completes using the internal count.
- **RESP:**
  - s_bvalid[g]=m_bvalid, s_bresp=m_bresp, m_bready=s_bready[g].
  - On the B handshake: rr_ptr←(g+1) mod N_REQ, grant←0, go to IDLE.
- Non-granted requesters see awready=wready=bvalid=0 at all times.
- beat_cnt is ALEN_WIDTH+1 bits wide, so awlen=all-ones (256 beats at 8 bits) does not wrap.

## Timing
- Reset (arst_axi=0, async) sets: state=IDLE, rr_ptr=0, grant=0, len_q=0, beat_cnt=0, len_err=0.
  - All m_* valid/ready and s_* ready/valid outputs read 0 while in reset.
- Reset mid-transaction aborts immediately. No B is forwarded and priority restarts at requester 0.
- All forwarding in ADDR/DATA/RESP is combinational from the registered grant: zero added latency per beat.
- Fixed overhead per transaction:
  - 2 cycles before m_awvalid can first assert (IDLE→ARB→ADDR);
  - 1 cycle from the B handshake until IDLE.
  - Back-to-back throughput with 1-beat bursts and all readies high is 5 cycles per transaction.
- The grant never changes between ARB and the B handshake, whatever the new requests.
- Requests arriving simultaneously resolve by rr_ptr order only. No requester waits more than N_REQ-1 transactions.
- AW of a later requester is never accepted while a B is outstanding (single outstanding transaction).

## Test plan
- **Reset values:** assert reset mid-DATA (grant=0010) → all outputs 0 immediately; after release, requester 0 wins the next arbitration even though rr_ptr was 2.
- **Single requester, full burst:** requester 2 issues a write with awlen=3, 4 beats 0xA0..0xA3, BRESP=OKAY.
  - m_awvalid appears 2 cycles after s_awvalid.
  - m_wlast is high only on 0xA3.
  - s_bvalid[2]=1 with bresp=0; grant returns to 0.
- **Round-robin:** all 4 requesters continuously request 1-beat writes → grant order 0,1,2,3,0. Each transaction is 5 cycles with readies held high.
- **Backpressure:** m_wready toggles 1,0,0,1 on a 4-beat burst → exactly 4 W handshakes, data in order, no beat dropped or duplicated.
- **Length mismatch:**
  - awlen=1 with s_wlast on beat 0 → len_err pulses once on beat 0; m_wlast is asserted on beat 1 only.
  - awlen=1 with no s_wlast → len_err pulses on beat 1.
- **Max length:** awlen=255 → 256 beats; m_wlast only on beat 255; beat_cnt does not wrap.
